// File: rtl/zerosoc_uart_rx_pkg.sv
// zerosoc_uart_rx_pkg: receiver state encoding and framing constants
package zerosoc_uart_rx_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_rx_state_e;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;
endpackage

// File: rtl/zerosoc_uart_rx_fifo.sv
// zerosoc_uart_rx_fifo: synchronous receive FIFO with occupancy and sticky head output
module zerosoc_uart_rx_fifo import zerosoc_uart_rx_pkg::*; #(
  parameter int Width = DATA_BITS,
  parameter int Depth = 4,
  localparam int AW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW-1:0] rd_idx;
  logic do_push, do_pop;
  assign level_o = wr_q - rd_q;
  assign full_o  = level_o == (AW+1)'(Depth);
  assign empty_o = wr_q == rd_q;
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;
  assign rd_idx  = empty_o ? rd_q[AW-1:0] - AW'(1) : rd_q[AW-1:0];
  assign rdata_o = mem_q[rd_idx];
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = wdata_i;
    wr_d = do_push ? wr_q + (AW+1)'(1) : wr_q;
    rd_d = do_pop ? rd_q + (AW+1)'(1) : rd_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/zerosoc_uart_rx.sv
// zerosoc_uart_rx: 16x oversampled UART receiver with parity, error pulses and receive FIFO
module zerosoc_uart_rx import zerosoc_uart_rx_pkg::*; #(
  parameter int DivWidth = 16,
  parameter int FifoDepth = 4,
  localparam int LvlW = $clog2(FifoDepth) + 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rx_i,
  input  logic                enable_i,
  input  logic [DivWidth-1:0] div_i,
  input  logic                parity_en_i,
  input  logic                parity_odd_i,
  output logic [7:0]          rdata_o,
  output logic                rvalid_o,
  input  logic                rready_i,
  output logic [LvlW-1:0]     level_o,
  output logic                busy_o,
  output logic                frame_err_o,
  output logic                parity_err_o,
  output logic                overrun_o
);
  uart_rx_state_e state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic prev_q, prev_d, rxs;
  logic [DivWidth-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0] samp_q, samp_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic par_err_q, par_err_d;
  logic frame_err_q, frame_err_d, parity_err_q, parity_err_d, overrun_q, overrun_d;
  logic tick, mid, wrap, start_det, push, full, empty;
  assign rxs  = sync_q[1];
  assign tick = enable_i && tick_cnt_q == div_i;
  assign mid  = tick && samp_q == 4'(MID_SAMPLE);
  assign wrap = tick && samp_q == 4'(OVERSAMPLE - 1);
  always_comb begin
    sync_d       = {sync_q[0], rx_i};
    prev_d       = rxs;
    state_d      = state_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_err_d    = par_err_q;
    start_det    = 1'b0;
    push         = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    case (state_q)
      ST_IDLE: if (enable_i && prev_q && !rxs) begin
        start_det = 1'b1;
        state_d   = ST_START;
        bit_d     = '0;
        par_err_d = 1'b0;
      end
      ST_START: state_d = (mid && rxs) ? ST_IDLE : wrap ? ST_DATA : ST_START;
      ST_DATA: begin
        if (mid) shift_d = {rxs, shift_q[7:1]};
        if (wrap) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'(DATA_BITS - 1)) state_d = parity_en_i ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (mid) par_err_d = rxs != (^shift_q ^ parity_odd_i);
        if (wrap) state_d = ST_STOP;
      end
      ST_STOP: if (mid) begin
        state_d      = ST_IDLE;
        frame_err_d  = !rxs;
        parity_err_d = rxs && par_err_q;
        push         = rxs && !par_err_q;
      end
      default: state_d = ST_IDLE;
    endcase
    if (!enable_i) state_d = ST_IDLE;
    tick_cnt_d = (!enable_i || tick || start_det) ? '0 : tick_cnt_q + DivWidth'(1);
    samp_d     = start_det ? 4'd0 : tick ? samp_q + 4'd1 : samp_q;
    overrun_d  = push && full && !rready_i;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q       <= 2'b11;
      prev_q       <= 1'b1;
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      samp_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      samp_q       <= samp_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end
  zerosoc_uart_rx_fifo #(.Width(8), .Depth(FifoDepth)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (rready_i),
    .wdata_i (shift_q),
    .rdata_o (rdata_o),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level_o)
  );
  assign rvalid_o     = !empty;
  assign busy_o       = state_q != ST_IDLE;
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;
  assign overrun_o    = overrun_q;
endmodule
